cpu_rd_port: RTL and testbench
==============================

// Module: cpu_rd_port
// PURPOSE
//  CPU-facing read port of one packet-memory ping-pong buffer; sits directly below cpu_adapter.
//  - Services word reads with a fixed, parameterisable latency.
//  - Owns the rdy/rdy_ack/acc/rej/done_ack handshake with cpu_adapter.
//  - Reports the CPU's accept/reject verdict to the buffer manager, then releases the buffer.
// PARAMETERS
//  ADDR_WIDTH  9   word address width into packet RAM
//  DATA_WIDTH  64  RAM word width, bits (bigword)
//  PLEN_WIDTH  32  packet length width, bytes
//  BUF_IN      0   extra register stages on addr/en before RAM (0 or 1)
//  BUF_OUT     0   extra register stages on RAM dout (0 or 1)
// PORTS
//  clk           in   1           clock
//  rst           in   1           reset, synchronous, active-low
//  pkt_full      in   1           level from buffer manager: buffer holds a complete packet
//  pkt_len       in   PLEN_WIDTH  packet length in bytes; valid while pkt_full=1
//  buf_done      out  1           verdict ready to buffer manager; held until buf_done_ack
//  buf_acc       out  1           verdict: 1=accept, 0=reject; valid with buf_done
//  buf_done_ack  in   1           buffer manager consumed verdict
//  rdy           out  1           to adapter: packet available for CPU
//  rdy_ack       in   1           adapter claims packet
//  acc           in   1           adapter: accept packet (1-cycle pulse)
//  rej           in   1           adapter: reject packet (1-cycle pulse)
//  done_ack      out  1           to adapter: verdict taken (1-cycle pulse)
//  rd_en         in   1           adapter read request
//  word_rd_addra in   ADDR_WIDTH  adapter word address
//  bigword       out  DATA_WIDTH  read data, @L
//  bigword_vld   out  1           read data valid, @L
//  byte_len      out  PLEN_WIDTH  latched packet length
//  ram_addr      out  ADDR_WIDTH  to RAM
//  ram_en        out  1           to RAM
//  ram_dout      in   DATA_WIDTH  RAM data, 1 cycle after ram_en
// BEHAVIOUR
//  - Reset (rst=0 at a clk edge):
//    - state=IDLE.
//    - Outputs 0: rdy, done_ack, buf_done, buf_acc, bigword_vld, bigword, byte_len, ram_en, ram_addr.
//    - Valid pipeline flushed; in-flight reads are dropped.
//  - FSM:
//    - IDLE:  pkt_full=1 -> OFFER; byte_len<=pkt_len on that transition.
//    - OFFER: rdy=1 (combinational from state). rdy_ack=1 -> OWNED.
//    - OWNED: reads serviced. acc|rej -> VERDICT; buf_acc<=acc (acc wins if both);
//             done_ack pulses 1 cycle on the transition.
//    - VERDICT: buf_done=1, buf_acc held. buf_done_ack=1 -> IDLE.
//               buf_done and buf_acc clear and byte_len<=0 on that transition.
//  - Ignored inputs:
//    - acc/rej outside OWNED; no done_ack.
//    - rdy_ack outside OFFER.
//    - pkt_full outside IDLE.
//  - Reads:
//    - ram_en = rd_en & (state==OWNED), and the request carries word_rd_addra, delayed by BUF_IN stages.
//    - The RAM adds 1 cycle; dout is then delayed by BUF_OUT stages.
//    - Latency L = 1+BUF_IN+BUF_OUT; bigword_vld is the request qualifier delayed L cycles.
//    - II=1: back-to-back reads return in order, one per cycle.
//    - rd_en outside OWNED: no RAM access, no vld.
//    - Reads issued in the same cycle as acc/rej are still serviced; in-flight reads complete after the verdict.
//    - bigword holds the last valid data when vld=0.
//  - No bounds check against byte_len; the adapter or CPU owns that.
// TESTING
//  1. Full cycle: rst, pkt_full=1, pkt_len=60 -> rdy=1 next cycle, byte_len=60;
//     rdy_ack -> rdy=0; acc -> done_ack 1 cycle, buf_done=1, buf_acc=1; buf_done_ack -> IDLE.
//  2. Latency sweep (BUF_IN,BUF_OUT)=(0,0),(1,0),(1,1):
//     read addr 5 in OWNED, RAM word5=0x0011223344556677 -> bigword_vld at +1/+2/+3 with that data.
//  3. Back-to-back reads of addr 0..7 every cycle -> 8 consecutive vld cycles, data in order.
//  4. rd_en in IDLE/OFFER -> ram_en=0, no vld; acc in OFFER -> no done_ack, stays OFFER.
//  5. acc=rej=1 same cycle in OWNED -> buf_acc=1; rej alone -> buf_acc=0.
//  6. rst=0 with 2 reads in flight, state=VERDICT -> next cycle state IDLE, all outputs 0, no vld afterwards.

Source files
------------

// File: rtl/cpu_rd_port.sv
// CPU-side read port of one packet-memory ping-pong buffer: fixed-latency word reads
// plus the offer / claim / verdict / release handshake between adapter and buffer manager.
module cpu_rd_port #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int PLEN_WIDTH = 32,
    parameter int BUF_IN     = 0,
    parameter int BUF_OUT    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_full,
    input  logic [PLEN_WIDTH-1:0] pkt_len,
    output logic                  buf_done,
    output logic                  buf_acc,
    input  logic                  buf_done_ack,
    output logic                  rdy,
    input  logic                  rdy_ack,
    input  logic                  acc,
    input  logic                  rej,
    output logic                  done_ack,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] word_rd_addra,
    output logic [DATA_WIDTH-1:0] bigword,
    output logic                  bigword_vld,
    output logic [PLEN_WIDTH-1:0] byte_len,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_en,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    localparam int LAT = 1 + BUF_IN + BUF_OUT;

    typedef enum logic [1:0] {IDLE, OFFER, OWNED, VERDICT} state_t;

    state_t                state, state_nxt;
    logic [PLEN_WIDTH-1:0] byte_len_nxt;
    logic                  buf_acc_nxt;
    logic                  done_ack_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            byte_len <= '0;
            buf_acc  <= 1'b0;
            done_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_len <= byte_len_nxt;
            buf_acc  <= buf_acc_nxt;
            done_ack <= done_ack_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_len_nxt = byte_len;
        buf_acc_nxt  = buf_acc;
        done_ack_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (pkt_full) begin
                    state_nxt    = OFFER;
                    byte_len_nxt = pkt_len;
                end
            end
            OFFER: begin
                if (rdy_ack) state_nxt = OWNED;
            end
            OWNED: begin
                // accept takes priority when both pulses land together
                if (acc || rej) begin
                    state_nxt    = VERDICT;
                    buf_acc_nxt  = acc;
                    done_ack_nxt = 1'b1;
                end
            end
            VERDICT: begin
                if (buf_done_ack) begin
                    state_nxt    = IDLE;
                    buf_acc_nxt  = 1'b0;
                    byte_len_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rdy      = (state == OFFER);
    assign buf_done = (state == VERDICT);

    // Request qualifier travels alongside the data: stage BUF_IN feeds the RAM, stage LAT is vld.
    logic           req;
    logic [LAT:1]   vld_sr;
    logic [LAT:0]   vld_pipe;

    assign req      = rd_en && (state == OWNED);
    assign vld_pipe = {vld_sr, req};

    always_ff @(posedge clk) begin
        if (!rst) vld_sr <= '0;
        else      vld_sr <= vld_pipe[LAT-1:0];
    end

    assign ram_en      = vld_pipe[BUF_IN];
    assign bigword_vld = vld_pipe[LAT];

    generate
        if (BUF_IN == 1) begin : g_in_reg
            logic [ADDR_WIDTH-1:0] addr_q;
            always_ff @(posedge clk) begin
                if (!rst) addr_q <= '0;
                else      addr_q <= req ? word_rd_addra : '0;
            end
            assign ram_addr = addr_q;
        end else begin : g_in_comb
            assign ram_addr = req ? word_rd_addra : '0;
        end

        if (BUF_OUT == 1) begin : g_out_reg
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (!rst)                 dout_q <= '0;
                else if (vld_pipe[LAT-1]) dout_q <= ram_dout;
            end
            assign bigword = dout_q;
        end else begin : g_out_comb
            // RAM data is live only in its valid cycle; the shadow keeps it visible afterwards
            logic [DATA_WIDTH-1:0] hold_q;
            always_ff @(posedge clk) begin
                if (!rst)               hold_q <= '0;
                else if (vld_pipe[LAT]) hold_q <= ram_dout;
            end
            assign bigword = vld_pipe[LAT] ? ram_dout : hold_q;
        end
    endgenerate

endmodule

// File: tb/tb_cpu_rd_port.sv
// Bench for cpu_rd_port: three latency variants driven in lockstep against a
// cycle-indexed request history and a handshake phase model.
module tb_cpu_rd_port;
    localparam int AW = 9;
    localparam int DW = 64;
    localparam int PW = 32;
    localparam int NI = 3;
    localparam int HN = 4096;
    localparam int S_IDLE = 0, S_OFFER = 1, S_OWNED = 2, S_VERDICT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, pkt_full, buf_done_ack, rdy_ack, acc, rej, rd_en;
    logic [PW-1:0] pkt_len;
    logic [AW-1:0] word_rd_addra;

    logic [NI-1:0]         buf_done_o, buf_acc_o, rdy_o, done_ack_o, vld_o, ram_en_o;
    logic [NI-1:0][DW-1:0] bigword_o;
    logic [DW-1:0]         ram_dout_o [NI];
    logic [NI-1:0][PW-1:0] byte_len_o;
    logic [NI-1:0][AW-1:0] ram_addr_o;
    logic [DW-1:0]         mem [0:(1<<AW)-1];

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            cpu_rd_port #(
                .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PLEN_WIDTH(PW),
                .BUF_IN(g > 0 ? 1 : 0), .BUF_OUT(g == 2 ? 1 : 0)
            ) dut (
                .clk(clk), .rst(rst), .pkt_full(pkt_full), .pkt_len(pkt_len),
                .buf_done(buf_done_o[g]), .buf_acc(buf_acc_o[g]), .buf_done_ack(buf_done_ack),
                .rdy(rdy_o[g]), .rdy_ack(rdy_ack), .acc(acc), .rej(rej), .done_ack(done_ack_o[g]),
                .rd_en(rd_en), .word_rd_addra(word_rd_addra),
                .bigword(bigword_o[g]), .bigword_vld(vld_o[g]), .byte_len(byte_len_o[g]),
                .ram_addr(ram_addr_o[g]), .ram_en(ram_en_o[g]), .ram_dout(ram_dout_o[g])
            );
        end
    endgenerate

    always @(posedge clk)
        for (int g = 0; g < NI; g++)
            if (ram_en_o[g]) ram_dout_o[g] <= mem[ram_addr_o[g]];

    // reference model
    int            m_state;
    logic [PW-1:0] m_len;
    logic          m_acc, m_done;
    bit            m_rst_seen;
    bit            req_h  [HN];
    logic [AW-1:0] addr_h [HN];
    logic [DW-1:0] last   [NI];
    int            bi  [NI] = '{0, 1, 1};
    int            lat [NI] = '{1, 2, 3};
    int            cyc_n = 0;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // inputs are already set (one time unit after the last edge); check, then advance one clock
    task automatic cyc();
        bit exp_en, exp_v;
        #1;
        if (cyc_n >= HN) begin
            $display("FAIL cycle_budget observed=%0d expected<%0d", cyc_n, HN);
            $fatal(1);
        end
        req_h[cyc_n]  = rd_en && (m_state == S_OWNED);
        addr_h[cyc_n] = word_rd_addra;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rdy[%0d]@%0d", g, cyc_n), rdy_o[g], m_state == S_OFFER);
            chk($sformatf("buf_done[%0d]@%0d", g, cyc_n), buf_done_o[g], m_state == S_VERDICT);
            chk($sformatf("buf_acc[%0d]@%0d", g, cyc_n), buf_acc_o[g], m_acc);
            chk($sformatf("done_ack[%0d]@%0d", g, cyc_n), done_ack_o[g], m_done);
            chk($sformatf("byte_len[%0d]@%0d", g, cyc_n), byte_len_o[g], m_len);
            exp_en = (cyc_n >= bi[g]) && req_h[cyc_n - bi[g]];
            chk($sformatf("ram_en[%0d]@%0d", g, cyc_n), ram_en_o[g], exp_en);
            if (exp_en)
                chk($sformatf("ram_addr[%0d]@%0d", g, cyc_n), ram_addr_o[g], addr_h[cyc_n - bi[g]]);
            if (m_rst_seen)
                chk($sformatf("rst_ram_addr[%0d]@%0d", g, cyc_n), ram_addr_o[g], 0);
            exp_v = (cyc_n >= lat[g]) && req_h[cyc_n - lat[g]];
            chk($sformatf("vld[%0d]@%0d", g, cyc_n), vld_o[g], exp_v);
            if (exp_v) last[g] = mem[addr_h[cyc_n - lat[g]]];
            chk($sformatf("bigword[%0d]@%0d", g, cyc_n), bigword_o[g], last[g]);
        end
        @(posedge clk);
        if (!rst) begin
            m_state = S_IDLE; m_len = '0; m_acc = 1'b0; m_done = 1'b0; m_rst_seen = 1'b1;
            for (int i = 0; i <= cyc_n; i++) req_h[i] = 1'b0;
            for (int g = 0; g < NI; g++) last[g] = '0;
        end else begin
            m_rst_seen = 1'b0;
            m_done     = 1'b0;
            case (m_state)
                S_IDLE:  if (pkt_full) begin m_state = S_OFFER; m_len = pkt_len; end
                S_OFFER: if (rdy_ack) m_state = S_OWNED;
                S_OWNED: if (acc || rej) begin m_state = S_VERDICT; m_acc = acc; m_done = 1'b1; end
                default: if (buf_done_ack) begin m_state = S_IDLE; m_acc = 1'b0; m_len = '0; end
            endcase
        end
        cyc_n++;
        #1;
    endtask

    task automatic offer_own(input logic [PW-1:0] len);
        pkt_full = 1'b1; pkt_len = len; cyc();
        pkt_full = 1'b0; rdy_ack = 1'b1; cyc();
        rdy_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
        mem[5] = 64'h0011223344556677;
        rst = 1'b0; pkt_full = 1'b0; pkt_len = '0; buf_done_ack = 1'b0; rdy_ack = 1'b0;
        acc = 1'b0; rej = 1'b0; rd_en = 1'b0; word_rd_addra = '0;
        @(posedge clk); #1;
        m_state = S_IDLE; m_len = '0; m_acc = 1'b0; m_done = 1'b0; m_rst_seen = 1'b1;
        for (int g = 0; g < NI; g++) last[g] = '0;
        cyc();
        rst = 1'b1;
        cyc();

        // full handshake, with reads and acc attempted while only offered
        pkt_full = 1'b1; pkt_len = 60; cyc();
        for (int g = 0; g < NI; g++) begin
            chk("t1_rdy", rdy_o[g], 1);
            chk("t1_len", byte_len_o[g], 60);
        end
        pkt_full = 1'b0; rd_en = 1'b1; word_rd_addra = 3; acc = 1'b1; cyc();
        acc = 1'b0; rd_en = 1'b0;
        for (int g = 0; g < NI; g++) chk("t4_offer_hold", rdy_o[g], 1);
        rdy_ack = 1'b1; cyc(); rdy_ack = 1'b0;
        for (int g = 0; g < NI; g++) chk("t1_rdy_low", rdy_o[g], 0);

        // latency sweep on word 5
        rd_en = 1'b1; word_rd_addra = 5; cyc(); rd_en = 1'b0;
        repeat (4) cyc();
        for (int g = 0; g < NI; g++) chk("t2_word5", bigword_o[g], 64'h0011223344556677);

        // back-to-back 0..7
        for (int a = 0; a < 8; a++) begin
            rd_en = 1'b1; word_rd_addra = AW'(a); cyc();
        end
        rd_en = 1'b0;
        repeat (4) cyc();

        repeat (24) begin
            rd_en = 1'($urandom_range(0, 1)); word_rd_addra = AW'($urandom_range(0, 511)); cyc();
        end

        // verdict issued alongside a read; the read must still complete
        rd_en = 1'b1; word_rd_addra = AW'($urandom_range(0, 511)); acc = 1'b1; cyc();
        acc = 1'b0; word_rd_addra = AW'($urandom_range(0, 511));
        for (int g = 0; g < NI; g++) begin
            chk("t1_done_ack", done_ack_o[g], 1);
            chk("t1_buf_acc", buf_acc_o[g], 1);
        end
        cyc(); rd_en = 1'b0;
        repeat (3) cyc();
        buf_done_ack = 1'b1; cyc(); buf_done_ack = 1'b0;
        cyc();

        // acc and rej together, then rej alone
        offer_own(PW'($urandom_range(1, 1500)));
        acc = 1'b1; rej = 1'b1; cyc(); acc = 1'b0; rej = 1'b0;
        for (int g = 0; g < NI; g++) chk("t5_both", buf_acc_o[g], 1);
        buf_done_ack = 1'b1; cyc(); buf_done_ack = 1'b0;
        offer_own(PW'($urandom_range(1, 1500)));
        rej = 1'b1; cyc(); rej = 1'b0;
        for (int g = 0; g < NI; g++) chk("t5_rej", buf_acc_o[g], 0);
        buf_done_ack = 1'b1; cyc(); buf_done_ack = 1'b0;

        // random traffic on every handshake input
        repeat (240) begin
            pkt_full      = ($urandom_range(0, 2) == 0);
            pkt_len       = $urandom;
            rdy_ack       = ($urandom_range(0, 3) == 0);
            acc           = ($urandom_range(0, 7) == 0);
            rej           = ($urandom_range(0, 7) == 0);
            buf_done_ack  = ($urandom_range(0, 3) == 0);
            rd_en         = 1'($urandom_range(0, 1));
            word_rd_addra = AW'($urandom_range(0, 511));
            cyc();
        end
        pkt_full = 1'b0; rd_en = 1'b0; rdy_ack = 1'b1; acc = 1'b1; rej = 1'b0; buf_done_ack = 1'b1;
        for (int i = 0; i < 8 && m_state != S_IDLE; i++) cyc();
        rdy_ack = 1'b0; acc = 1'b0; buf_done_ack = 1'b0;
        chk("drain_idle", rdy_o[0] | buf_done_o[0], 0);

        // reset with reads in flight while in VERDICT
        offer_own(PW'($urandom_range(1, 1500)));
        rd_en = 1'b1; word_rd_addra = AW'($urandom_range(0, 511)); cyc();
        rej = 1'b1; word_rd_addra = AW'($urandom_range(0, 511)); cyc();
        rej = 1'b0; rd_en = 1'b0; rst = 1'b0; cyc();
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            chk("t6_vld", vld_o[g], 0);
            chk("t6_buf_done", buf_done_o[g], 0);
            chk("t6_bigword", bigword_o[g], 0);
        end
        repeat (5) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
